// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS core pipeline-control slice.
// Used by the hazard detector and the stall sequencer.
package mips_pkg;

  localparam int          RA_W      = 5;
  localparam logic [4:0]  REG_ZERO  = 5'd0;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Per-cycle operating mode, listed in decreasing priority.
  typedef enum logic [2:0] {
    MODE_RESET,
    MODE_FREEZE,
    MODE_HAZARD,
    MODE_IWAIT,
    MODE_RUN
  } mode_e;

endpackage

// File: rtl/hazard_detect.sv
// Combinational hazard classifier for the instruction in ID.
// Reports how many bubble cycles are needed (0, 1 or 2).
module hazard_detect #(
  parameter int RA_W = 5
) (
  input  logic [RA_W-1:0] id_rs,
  input  logic [RA_W-1:0] id_rt,
  input  logic            id_uses_rs,
  input  logic            id_uses_rt,
  input  logic            id_is_branch,
  input  logic            ex_mem_read,
  input  logic            ex_reg_write,
  input  logic [RA_W-1:0] ex_rd,
  input  logic            mem_mem_read,
  input  logic [RA_W-1:0] mem_rd,
  output logic [1:0]      need_o
);
  import mips_pkg::*;

  logic ex_match;
  logic mem_match;

  // Writes to $0 are discarded by the register file, so they never create a dependency.
  function automatic logic reg_match(input logic [RA_W-1:0] r,
                                     input logic [RA_W-1:0] rs,
                                     input logic [RA_W-1:0] rt,
                                     input logic            use_rs,
                                     input logic            use_rt);
    return (r != RA_W'(REG_ZERO)) && ((use_rs && (r == rs)) || (use_rt && (r == rt)));
  endfunction

  assign ex_match  = reg_match(ex_rd,  id_rs, id_rt, id_uses_rs, id_uses_rt);
  assign mem_match = reg_match(mem_rd, id_rs, id_rt, id_uses_rs, id_uses_rt);

  always_comb begin
    need_o = 2'd0;
    if (id_is_branch) begin
      if (ex_mem_read && ex_match)
        need_o = 2'd2;
      else if ((ex_reg_write && ex_match) || (mem_mem_read && mem_match))
        need_o = 2'd1;
    end else if (ex_mem_read && ex_match) begin
      need_o = 2'd1;
    end
  end

endmodule

// File: rtl/hazard_stall_controller.sv
// Pipeline load-enable sequencer: load-use / branch-operand stalls, imem wait and dmem freeze.
// Only the remaining-stall count and the stall-cycle counter are registered.
module hazard_stall_controller #(
  parameter int RA_W   = 5,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [RA_W-1:0]   id_rs,
  input  logic [RA_W-1:0]   id_rt,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              id_is_branch,
  input  logic              ex_mem_read,
  input  logic              ex_reg_write,
  input  logic [RA_W-1:0]   ex_rd,
  input  logic              mem_mem_read,
  input  logic [RA_W-1:0]   mem_rd,
  input  logic              imem_ready,
  input  logic              dmem_busy,
  output logic              pc_le,
  output logic              if_id_le,
  output logic              if_id_nop,
  output logic              id_ex_bubble,
  output logic              pipe_freeze,
  output logic [PERF_W-1:0] stall_cycles
);
  import mips_pkg::*;

  logic [1:0]        need;
  logic [1:0]        stall_cnt_q, stall_cnt_d;
  logic [PERF_W-1:0] stall_cycles_q, stall_cycles_d;
  mode_e             mode;

  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    return (&v) ? v : v + PERF_W'(1);
  endfunction

  hazard_detect #(.RA_W(RA_W)) u_detect (
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rs   (id_uses_rs),
    .id_uses_rt   (id_uses_rt),
    .id_is_branch (id_is_branch),
    .ex_mem_read  (ex_mem_read),
    .ex_reg_write (ex_reg_write),
    .ex_rd        (ex_rd),
    .mem_mem_read (mem_mem_read),
    .mem_rd       (mem_rd),
    .need_o       (need)
  );

  // Once a stall is in progress the detector is ignored; the count alone finishes it.
  always_comb begin
    if (reset)                                     mode = MODE_RESET;
    else if (dmem_busy)                            mode = MODE_FREEZE;
    else if ((stall_cnt_q != 2'd0) || (need != 2'd0)) mode = MODE_HAZARD;
    else if (!imem_ready)                          mode = MODE_IWAIT;
    else                                           mode = MODE_RUN;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q    <= 2'd0;
      stall_cycles_q <= '0;
    end else begin
      stall_cnt_q    <= stall_cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  always_comb begin
    stall_cnt_d    = stall_cnt_q;
    stall_cycles_d = stall_cycles_q;
    case (mode)
      MODE_HAZARD: stall_cnt_d = (stall_cnt_q == 2'd0) ? need - 2'd1 : stall_cnt_q - 2'd1;
      MODE_IWAIT,
      MODE_RUN:    stall_cnt_d = 2'd0;
      default:     stall_cnt_d = stall_cnt_q;
    endcase
    if (!pc_le)
      stall_cycles_d = sat_inc(stall_cycles_q);
  end

  always_comb begin
    pc_le        = 1'b0;
    if_id_le     = 1'b0;
    if_id_nop    = 1'b0;
    id_ex_bubble = 1'b0;
    pipe_freeze  = 1'b0;
    case (mode)
      MODE_RESET:  id_ex_bubble = 1'b1;
      MODE_FREEZE: pipe_freeze  = 1'b1;
      MODE_HAZARD: id_ex_bubble = 1'b1;
      MODE_IWAIT: begin
        if_id_le  = 1'b1;
        if_id_nop = 1'b1;
      end
      default: begin
        pc_le    = 1'b1;
        if_id_le = 1'b1;
      end
    endcase
  end

  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller; a narrow stall counter makes saturation reachable.
module tb_hazard_stall_controller;

  localparam int RA_W   = 5;
  localparam int PERF_W = 3;

  // {pc_le, if_id_le, if_id_nop, id_ex_bubble, pipe_freeze}
  localparam logic [4:0] C_RUN    = 5'b11000;
  localparam logic [4:0] C_HAZARD = 5'b00010;
  localparam logic [4:0] C_IWAIT  = 5'b01100;
  localparam logic [4:0] C_FREEZE = 5'b00001;
  localparam logic [4:0] C_RESET  = 5'b00010;

  logic              clk = 1'b0;
  logic              reset;
  logic [RA_W-1:0]   id_rs, id_rt, ex_rd, mem_rd;
  logic              id_uses_rs, id_uses_rt, id_is_branch;
  logic              ex_mem_read, ex_reg_write, mem_mem_read;
  logic              imem_ready, dmem_busy;
  logic              pc_le, if_id_le, if_id_nop, id_ex_bubble, pipe_freeze;
  logic [PERF_W-1:0] stall_cycles;
  logic [4:0]        ctl;

  int errors = 0;
  int checks = 0;

  assign ctl = {pc_le, if_id_le, if_id_nop, id_ex_bubble, pipe_freeze};

  hazard_stall_controller #(.RA_W(RA_W), .PERF_W(PERF_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rs   (id_uses_rs),
    .id_uses_rt   (id_uses_rt),
    .id_is_branch (id_is_branch),
    .ex_mem_read  (ex_mem_read),
    .ex_reg_write (ex_reg_write),
    .ex_rd        (ex_rd),
    .mem_mem_read (mem_mem_read),
    .mem_rd       (mem_rd),
    .imem_ready   (imem_ready),
    .dmem_busy    (dmem_busy),
    .pc_le        (pc_le),
    .if_id_le     (if_id_le),
    .if_id_nop    (if_id_nop),
    .id_ex_bubble (id_ex_bubble),
    .pipe_freeze  (pipe_freeze),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_is_branch = 1'b0;
    ex_mem_read = 1'b0; ex_reg_write = 1'b0; ex_rd = 5'd0;
    mem_mem_read = 1'b0; mem_rd = 5'd0;
    imem_ready = 1'b1; dmem_busy = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    tick();
    reset = 1'b0;
    #1;
  endtask

  // lw $5 in EX, beq $5,$6 in ID
  task automatic branch_after_load();
    id_rs = 5'd5; id_rt = 5'd6; id_uses_rs = 1'b1; id_uses_rt = 1'b1; id_is_branch = 1'b1;
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd5;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    branch_after_load();
    checks++;
    if (ctl !== C_RESET) begin
      errors++; $display("FAIL reset_outputs: got %b want %b", ctl, C_RESET);
    end
    tick();
    checks++;
    if (stall_cycles !== 3'd0) begin
      errors++; $display("FAIL reset_counter: got %0d want 0", stall_cycles);
    end
    reset = 1'b0;
    idle();
    checks++;
    if (ctl !== C_RUN) begin
      errors++; $display("FAIL reset_release_run: got %b want %b", ctl, C_RUN);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    id_rs = 5'd2; id_rt = 5'd4; id_uses_rs = 1'b1; id_uses_rt = 1'b1;
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd2;
    #1;
    checks++;
    if (ctl !== C_HAZARD) begin
      errors++; $display("FAIL load_use_bubble: got %b want %b", ctl, C_HAZARD);
    end
    tick();
    ex_mem_read = 1'b0; ex_reg_write = 1'b0; ex_rd = 5'd0;
    mem_mem_read = 1'b1; mem_rd = 5'd2;
    #1;
    checks++;
    if (ctl !== C_RUN) begin
      errors++; $display("FAIL load_use_resume: got %b want %b", ctl, C_RUN);
    end
    tick();
    checks++;
    if (stall_cycles !== 3'd1) begin
      errors++; $display("FAIL load_use_count: got %0d want 1", stall_cycles);
    end
  endtask

  task automatic test_branch_after_load();
    do_reset();
    branch_after_load();
    checks++;
    if (ctl !== C_HAZARD) begin
      errors++; $display("FAIL branch_bubble1: got %b want %b", ctl, C_HAZARD);
    end
    tick();
    ex_mem_read = 1'b0; ex_reg_write = 1'b0; ex_rd = 5'd0;
    #1;
    checks++;
    if (ctl !== C_HAZARD) begin
      errors++; $display("FAIL branch_bubble2: got %b want %b", ctl, C_HAZARD);
    end
    tick();
    mem_mem_read = 1'b0;
    #1;
    checks++;
    if (ctl !== C_RUN) begin
      errors++; $display("FAIL branch_resume: got %b want %b", ctl, C_RUN);
    end
    tick();
    checks++;
    if (stall_cycles !== 3'd2) begin
      errors++; $display("FAIL branch_count: got %0d want 2", stall_cycles);
    end
  endtask

  task automatic test_branch_after_alu();
    do_reset();
    id_rs = 5'd7; id_uses_rs = 1'b1; id_is_branch = 1'b1;
    ex_reg_write = 1'b1; ex_rd = 5'd7;
    #1;
    checks++;
    if (ctl !== C_HAZARD) begin
      errors++; $display("FAIL branch_alu_bubble: got %b want %b", ctl, C_HAZARD);
    end
    tick();
    ex_reg_write = 1'b0; ex_rd = 5'd0;
    #1;
    checks++;
    if (ctl !== C_RUN) begin
      errors++; $display("FAIL branch_alu_resume: got %b want %b", ctl, C_RUN);
    end
  endtask

  task automatic test_reg_zero();
    do_reset();
    id_rs = 5'd0; id_uses_rs = 1'b1; ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd0;
    #1;
    for (int i = 0; i < 2; i++) begin
      id_is_branch = (i == 1);
      #1;
      checks++;
      if (ctl !== C_RUN) begin
        errors++; $display("FAIL reg_zero_cycle%0d: got %b want %b", i, ctl, C_RUN);
      end
      tick();
    end
    checks++;
    if (stall_cycles !== 3'd0) begin
      errors++; $display("FAIL reg_zero_count: got %0d want 0", stall_cycles);
    end
  endtask

  task automatic test_freeze_in_stall();
    do_reset();
    branch_after_load();
    tick();
    ex_mem_read = 1'b0; ex_reg_write = 1'b0; ex_rd = 5'd0;
    dmem_busy = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ctl !== C_FREEZE) begin
        errors++; $display("FAIL freeze_cycle%0d: got %b want %b", i, ctl, C_FREEZE);
      end
      tick();
    end
    dmem_busy = 1'b0;
    #1;
    checks++;
    if (ctl !== C_HAZARD) begin
      errors++; $display("FAIL freeze_then_bubble: got %b want %b", ctl, C_HAZARD);
    end
    tick();
    checks++;
    if (ctl !== C_RUN) begin
      errors++; $display("FAIL freeze_resume: got %b want %b", ctl, C_RUN);
    end
    checks++;
    if (stall_cycles !== 3'd5) begin
      errors++; $display("FAIL freeze_count: got %0d want 5", stall_cycles);
    end
  endtask

  task automatic test_iwait();
    do_reset();
    imem_ready = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (ctl !== C_IWAIT) begin
        errors++; $display("FAIL iwait_cycle%0d: got %b want %b", i, ctl, C_IWAIT);
      end
      tick();
    end
    checks++;
    if (stall_cycles !== 3'd2) begin
      errors++; $display("FAIL iwait_count: got %0d want 2", stall_cycles);
    end
    // Instruction memory not ready while a load-use hazard is pending: hazard wins.
    id_rs = 5'd3; id_uses_rs = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd3;
    #1;
    checks++;
    if (ctl !== C_HAZARD) begin
      errors++; $display("FAIL iwait_under_hazard: got %b want %b", ctl, C_HAZARD);
    end
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    branch_after_load();
    tick();
    reset = 1'b1;
    #1;
    checks++;
    if (ctl !== C_RESET) begin
      errors++; $display("FAIL midstall_reset_outputs: got %b want %b", ctl, C_RESET);
    end
    tick();
    checks++;
    if (stall_cycles !== 3'd0) begin
      errors++; $display("FAIL midstall_reset_count: got %0d want 0", stall_cycles);
    end
    reset = 1'b0;
    idle();
    checks++;
    if (ctl !== C_RUN) begin
      errors++; $display("FAIL midstall_run: got %b want %b", ctl, C_RUN);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    imem_ready = 1'b0;
    #1;
    for (int i = 0; i < 9; i++) tick();
    checks++;
    if (stall_cycles !== 3'd7) begin
      errors++; $display("FAIL saturate: got %0d want 7", stall_cycles);
    end
  endtask

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_load_use();
    test_branch_after_load();
    test_branch_after_alu();
    test_reg_zero();
    test_freeze_in_stall();
    test_iwait();
    test_reset_mid_stall();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
